if_fetch: RTL
=============

// Module: if_fetch
// PURPOSE
//  Instruction-fetch stage directly upstream of the decode stage. Holds the fetch PC, issues
//  in-order requests on a req/gnt/rvalid instruction-memory port and buffers returned words
//  in a DEPTH-entry prefetch FIFO. Presents {pc, instr} to decode with valid/ready.
//  On a branch, jump or trap redirect it flushes the FIFO and drops stale in-flight responses.
// PARAMETERS
//  DEPTH     2             prefetch entries; also max outstanding + discarded requests (>=1)
//  RESET_PC  32'h8000_0000 first fetch address after reset
// PORTS
//  clk             in   1            clock
//  rst_n           in   1            async active-low reset
//  imem_req_o      out  1            fetch request
//  imem_addr_o     out  `PC_WIDTH    fetch address, word aligned
//  imem_gnt_i      in   1            request accepted this cycle (only counted while req high)
//  imem_rvalid_i   in   1            response valid, in request order, >=1 cycle after gnt
//  imem_rdata_i    in   `INSTR_WIDTH returned instruction
//  imem_err_i      in   1            bus error, qualified by rvalid
//  redirect_i      in   1            flush and restart fetch
//  redirect_pc_i   in   `PC_WIDTH    new fetch PC; bits [1:0] treated as 0
//  id_valid_o      out  1            head entry valid to decode
//  id_ready_i      in   1            decode accepts head
//  id_pc_o         out  `PC_WIDTH    head PC
//  id_instr_o      out  `INSTR_WIDTH head instruction; 32'h0000_0013 (NOP) when !id_valid_o
//  id_excp_ifetch_err_o out 1        head entry returned imem_err_i (0 when !id_valid_o)
// BEHAVIOUR
//  - Reset (async assert, sync release): fetch_pc=RESET_PC, FIFO empty, discard_cnt=0,
//    imem_req_o=0, id_valid_o=0, id_excp_ifetch_err_o=0. First req is combinational after release.
//  - FIFO entry = {pc, instr, err, filled}. An entry is allocated on req&gnt with pc=fetch_pc,
//    filled=0. The oldest unfilled entry is filled on rvalid when discard_cnt==0.
//  - imem_req_o = !redirect_i && (alloc_cnt + discard_cnt < DEPTH); imem_addr_o = fetch_pc.
//    On req&gnt, fetch_pc += 4. Wraps modulo 2^PC_WIDTH.
//  - id_valid_o = head.filled (registered). Pop on id_valid_o&id_ready_i.
//    Minimum latency is gnt at cycle N, rvalid at N+1, id_valid_o at N+2.
//    Steady zero-wait throughput is 1 instr/cycle once DEPTH>=2.
//  - Alloc and pop in the same cycle are both legal; FIFO full blocks req only, never a pop.
//  - Redirect (1 cycle): fetch_pc<=redirect_pc_i; all entries cleared; decode pop ignored.
//    discard_cnt <= discard_cnt + unfilled_entries - (rvalid_i ? 1 : 0).
//    A rvalid in the redirect cycle is dropped.
//  - While discard_cnt>0, each rvalid decrements it and is dropped; new requests are still
//    allowed within the credit limit.
//  - Consecutive redirects: each redirect applies the same rules; the last redirect_pc wins.
//  - rvalid with no unfilled entry and discard_cnt==0 is a protocol violation; the bench
//    asserts it never occurs. RTL behaviour is don't-care.
//  - No outputs depend combinationally on imem_rvalid_i or imem_rdata_i.
// TESTING
//  1 Reset: rst_n low then high -> imem_req_o=1, imem_addr_o=0x8000_0000, id_valid_o=0,
//    id_instr_o=0x0000_0013.
//  2 Zero-wait memory (gnt=1, rvalid 1 cycle later), id_ready=1 -> id_pc_o=0x8000_0000,
//    0x8000_0004, 0x8000_0008 on consecutive cycles, first one 2 cycles after first gnt.
//  3 id_ready=0 -> exactly DEPTH grants, then imem_req_o=0. Release id_ready -> in-order
//    drain with no duplicate or lost PC.
//  4 Two requests outstanding, redirect_pc=0x8000_0100 -> both responses dropped, req high
//    meanwhile under credit limit, next id_pc_o=0x8000_0100 with its own rdata.
//  5 Redirect in the same cycle as rvalid and as an id pop -> that response is dropped,
//    no pop is counted, discard_cnt = unfilled-1, next id_pc_o=redirect_pc.
//  6 imem_err_i on the response for 0x8000_0008 -> id_excp_ifetch_err_o=1 with
//    id_pc_o=0x8000_0008 only. Async reset mid-burst -> empty FIFO and fetch restarts
//    at RESET_PC.

Source files
------------

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction-fetch stage with prefetch FIFO and redirect flush
//
// Purpose: holds the fetch PC and issues in-order word fetches on a
// req/gnt/rvalid instruction-memory port. Returned words are buffered in a
// DEPTH-entry prefetch FIFO and presented to decode as {pc, instr} with
// valid/ready. A redirect flushes the FIFO and drops responses still in flight.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   imem_req_o/addr_o     fetch request and word-aligned address
//   imem_gnt_i            request accepted (only meaningful while req is high)
//   imem_rvalid_i/rdata_i/err_i  in-order response, error qualified by rvalid
//   redirect_i/pc_i       flush and restart fetch at redirect_pc_i (bits [1:0] ignored)
//   id_valid_o/ready_i    head-entry handshake to decode
//   id_pc_o/instr_o       head PC and instruction (NOP while not valid)
//   id_excp_ifetch_err_o  head entry returned a bus error
module if_fetch #(
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned DEPTH       = 2,
  parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req_o,
  output logic [PC_WIDTH-1:0]    imem_addr_o,
  input  logic                   imem_gnt_i,
  input  logic                   imem_rvalid_i,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
  input  logic                   imem_err_i,
  input  logic                   redirect_i,
  input  logic [PC_WIDTH-1:0]    redirect_pc_i,
  output logic                   id_valid_o,
  input  logic                   id_ready_i,
  output logic [PC_WIDTH-1:0]    id_pc_o,
  output logic [INSTR_WIDTH-1:0] id_instr_o,
  output logic                   id_excp_ifetch_err_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = INSTR_WIDTH'(32'h0000_0013);
  localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

  // Ring-buffer storage; entries are allocated at tail_ptr, filled in order at
  // fill_ptr and consumed at head_ptr.
  logic [PC_WIDTH-1:0]    pc_q    [DEPTH];
  logic [INSTR_WIDTH-1:0] instr_q [DEPTH];
  logic                   err_q   [DEPTH];
  logic                   filled_q[DEPTH];

  logic [PC_WIDTH-1:0] fetch_pc;
  logic [PW-1:0]       head_ptr, tail_ptr, fill_ptr;
  logic [CW-1:0]       occ_cnt;       // allocated entries
  logic [CW-1:0]       unfilled_cnt;  // allocated entries still waiting on rvalid
  logic [CW-1:0]       discard_cnt;   // in-flight responses to drop after a redirect

  logic          pop, alloc, fill, drop, credit_ok;
  logic [CW-1:0] occ_after_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == LAST_IDX) return '0;
    return p + 1'b1;
  endfunction

  always_comb begin
    id_valid_o    = filled_q[head_ptr];
    pop           = id_valid_o && id_ready_i && !redirect_i;
    // A slot freed by this cycle's pop may be refilled by a grant in the same
    // cycle; this is what sustains one instruction per cycle with DEPTH=2.
    occ_after_pop = occ_cnt - CW'(pop);
    credit_ok     = ({1'b0, occ_after_pop} + {1'b0, discard_cnt}) < DEPTH_LIM;
    // Gated by rst_n so the port stays quiet while reset is asserted.
    imem_req_o    = rst_n && !redirect_i && credit_ok;
    imem_addr_o   = fetch_pc;
    alloc         = imem_req_o && imem_gnt_i;
    fill          = imem_rvalid_i && !redirect_i && (discard_cnt == '0) && (unfilled_cnt != '0);
    drop          = imem_rvalid_i && !redirect_i && (discard_cnt != '0);
  end

  always_comb begin
    id_pc_o              = pc_q[head_ptr];
    id_instr_o           = id_valid_o ? instr_q[head_ptr] : NOP_INSTR;
    id_excp_ifetch_err_o = id_valid_o && err_q[head_ptr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc     <= RESET_PC;
      head_ptr     <= '0;
      tail_ptr     <= '0;
      fill_ptr     <= '0;
      occ_cnt      <= '0;
      unfilled_cnt <= '0;
      discard_cnt  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) filled_q[i] <= 1'b0;
    end else if (redirect_i) begin
      fetch_pc     <= {redirect_pc_i[PC_WIDTH-1:2], 2'b00};
      head_ptr     <= '0;
      tail_ptr     <= '0;
      fill_ptr     <= '0;
      occ_cnt      <= '0;
      unfilled_cnt <= '0;
      for (int i = 0; i < int'(DEPTH); i++) filled_q[i] <= 1'b0;
      // Every unfilled entry still owes a response; a response arriving in
      // this cycle settles one of those debts immediately. The guard keeps a
      // stray rvalid from wrapping the counter.
      discard_cnt  <= discard_cnt + unfilled_cnt
                      - CW'(imem_rvalid_i && ((discard_cnt != '0) || (unfilled_cnt != '0)));
    end else begin
      if (alloc) begin
        fetch_pc <= fetch_pc + PC_WIDTH'(4);
        tail_ptr <= ptr_inc(tail_ptr);
      end
      // Pop and fill never target the same slot: the head is filled, the
      // fill slot is not.
      if (pop) begin
        filled_q[head_ptr] <= 1'b0;
        head_ptr           <= ptr_inc(head_ptr);
      end
      if (fill) begin
        filled_q[fill_ptr] <= 1'b1;
        fill_ptr           <= ptr_inc(fill_ptr);
      end
      occ_cnt      <= occ_cnt + CW'(alloc) - CW'(pop);
      unfilled_cnt <= unfilled_cnt + CW'(alloc) - CW'(fill);
      if (drop) discard_cnt <= discard_cnt - 1'b1;
    end
  end

  // Payload storage needs no reset: it is only observed through filled_q.
  always_ff @(posedge clk) begin
    if (alloc) pc_q[tail_ptr] <= fetch_pc;
    if (fill) begin
      instr_q[fill_ptr] <= imem_rdata_i;
      err_q[fill_ptr]   <= imem_err_i;
    end
  end

endmodule
